// File: rtl/route_opt_engine.sv
// Route register file with streaming load/read and in-place Or-opt / 2-opt moves.
// Moves run word-serially (Or-opt) or pair-serially (2-opt) while busy is high.
module route_opt_engine #(
   parameter int CITY_W = 7,
   parameter int LANES  = 8,
   parameter int N_CITY = 32,
   localparam int IW    = (N_CITY > 2) ? $clog2(N_CITY) : 1,
   localparam int NW    = N_CITY / LANES,
   localparam int WW    = (NW > 2) ? $clog2(NW) : 1,
   localparam int DW    = LANES * CITY_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [IW-1:0] cmd_k,
   input  logic [IW-1:0] cmd_l,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int LW = $clog2(LANES);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StLoad = 3'd1;
   localparam logic [2:0] StOrf  = 3'd2;
   localparam logic [2:0] StOrb  = 3'd3;
   localparam logic [2:0] StRev  = 3'd4;
   localparam logic [2:0] StRead = 3'd5;

   localparam logic [2:0] OpNop  = 3'd0;
   localparam logic [2:0] OpLoad = 3'd1;
   localparam logic [2:0] OpOrf  = 3'd2;
   localparam logic [2:0] OpOrb  = 3'd3;
   localparam logic [2:0] OpTwo  = 3'd4;
   localparam logic [2:0] OpRead = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [CITY_W-1:0] route_q [N_CITY];
   logic [CITY_W-1:0] route_d [N_CITY];
   logic [WW-1:0]     wc_q, wc_d;
   logic [WW-1:0]     rc_q, rc_d;
   logic [CITY_W-1:0] carry_q, carry_d;
   // k/l hold the move bounds; during 2-opt they double as the lo/hi swap pointers
   logic [IW-1:0]     k_q, k_d;
   logic [IW-1:0]     l_q, l_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              move_legal;

   function automatic logic [WW-1:0] word_of(input logic [IW-1:0] pos);
      logic [IW-1:0] sh;
      sh = pos >> LW;
      return sh[WW-1:0];
   endfunction

   assign move_legal = (cmd_k < cmd_l) && (32'(cmd_l) < 32'(N_CITY));

   always_comb begin
      state_d = state_q;
      route_d = route_q;
      wc_d    = wc_q;
      rc_d    = rc_q;
      carry_d = carry_q;
      k_d     = k_q;
      l_d     = l_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OpNop: ;
                  OpLoad: begin
                     state_d = StLoad;
                     wc_d    = '0;
                  end
                  OpRead: begin
                     state_d = StRead;
                     rc_d    = '0;
                  end
                  OpOrf, OpOrb, OpTwo: begin
                     if (!move_legal) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                     end else begin
                        k_d = cmd_k;
                        l_d = cmd_l;
                        if (cmd_op == OpOrf) begin
                           state_d = StOrf;
                           carry_d = route_q[cmd_k];
                           wc_d    = word_of(cmd_k);
                        end else if (cmd_op == OpOrb) begin
                           state_d = StOrb;
                           carry_d = route_q[cmd_l];
                           wc_d    = word_of(cmd_l);
                        end else begin
                           state_d = StRev;
                        end
                     end
                  end
                  default: begin
                     err_d  = 1'b1;
                     done_d = 1'b1;
                  end
               endcase
            end
         end
         StLoad: begin
            if (in_valid) begin
               for (int j = 0; j < N_CITY; j++) begin
                  if (WW'(j / LANES) == wc_q) begin
                     route_d[j] = in_data[(j % LANES) * CITY_W +: CITY_W];
                  end
               end
               if (wc_q == WW'(NW - 1)) begin
                  state_d = StIdle;
                  wc_d    = '0;
                  done_d  = 1'b1;
               end else begin
                  wc_d = wc_q + 1'b1;
               end
            end
         end
         StOrf: begin
            // Ascending: route_q[j+1] in the next word is still unmodified
            for (int j = 0; j < N_CITY; j++) begin
               if (WW'(j / LANES) == wc_q) begin
                  if (IW'(j) >= k_q && IW'(j) < l_q) begin
                     route_d[j] = route_q[(j + 1) % N_CITY];
                  end else if (IW'(j) == l_q) begin
                     route_d[j] = carry_q;
                  end
               end
            end
            if (wc_q == word_of(l_q)) begin
               state_d = StIdle;
               wc_d    = '0;
               done_d  = 1'b1;
            end else begin
               wc_d = wc_q + 1'b1;
            end
         end
         StOrb: begin
            for (int j = 0; j < N_CITY; j++) begin
               if (WW'(j / LANES) == wc_q) begin
                  if (IW'(j) > k_q && IW'(j) <= l_q) begin
                     route_d[j] = route_q[(j + N_CITY - 1) % N_CITY];
                  end else if (IW'(j) == k_q) begin
                     route_d[j] = carry_q;
                  end
               end
            end
            if (wc_q == word_of(k_q)) begin
               state_d = StIdle;
               wc_d    = '0;
               done_d  = 1'b1;
            end else begin
               wc_d = wc_q - 1'b1;
            end
         end
         StRev: begin
            route_d[k_q] = route_q[l_q];
            route_d[l_q] = route_q[k_q];
            if (l_q - k_q <= IW'(2)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               k_d = k_q + 1'b1;
               l_d = l_q - 1'b1;
            end
         end
         StRead: begin
            if (out_ready) begin
               if (rc_q == WW'(NW - 1)) begin
                  state_d = StIdle;
                  rc_d    = '0;
                  done_d  = 1'b1;
               end else begin
                  rc_d = rc_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         for (int j = 0; j < N_CITY; j++) begin
            route_q[j] <= CITY_W'(j);
         end
         wc_q    <= '0;
         rc_q    <= '0;
         carry_q <= '0;
         k_q     <= '0;
         l_q     <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         route_q <= route_d;
         wc_q    <= wc_d;
         rc_q    <= rc_d;
         carry_q <= carry_d;
         k_q     <= k_d;
         l_q     <= l_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      out_data = '0;
      for (int j = 0; j < N_CITY; j++) begin
         if (WW'(j / LANES) == rc_q) begin
            out_data[(j % LANES) * CITY_W +: CITY_W] = route_q[j];
         end
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign in_ready  = (state_q == StLoad);
   assign out_valid = (state_q == StRead);
   assign out_last  = out_valid && (rc_q == WW'(NW - 1));
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_route_opt_engine.sv
// Scoreboard bench for route_opt_engine: a reference route model supplies every
// expected read word, busy length and done/err pulse.
module tb_route_opt_engine;

   localparam int CW = 7;
   localparam int LN = 8;
   localparam int NC = 32;
   localparam int NW = NC / LN;
   localparam int IW = 5;
   localparam int DW = LN * CW;

   localparam logic [2:0] OpNop  = 3'd0;
   localparam logic [2:0] OpLoad = 3'd1;
   localparam logic [2:0] OpOrf  = 3'd2;
   localparam logic [2:0] OpOrb  = 3'd3;
   localparam logic [2:0] OpTwo  = 3'd4;
   localparam logic [2:0] OpRead = 3'd5;

   logic          clk;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [IW-1:0] cmd_k;
   logic [IW-1:0] cmd_l;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          err;

   int            m [NC];
   int            n_vec;
   int            n_err;
   logic [DW-1:0] sb [$];

   route_opt_engine #(
      .CITY_W (CW),
      .LANES  (LN),
      .N_CITY (NC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_k     (cmd_k),
      .cmd_l     (cmd_l),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] pack(input int w);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < LN; i++) r[i*CW +: CW] = CW'(m[w*LN + i]);
      return r;
   endfunction

   task automatic m_ident();
      for (int j = 0; j < NC; j++) m[j] = j;
   endtask

   task automatic m_orf(input int k, input int l);
      int c;
      c = m[k];
      for (int j = k; j < l; j++) m[j] = m[j+1];
      m[l] = c;
   endtask

   task automatic m_orb(input int k, input int l);
      int c;
      c = m[l];
      for (int j = l; j > k; j--) m[j] = m[j-1];
      m[k] = c;
   endtask

   task automatic m_two(input int k, input int l);
      int t;
      for (int i = 0; k + i < l - i; i++) begin
         t = m[k+i];
         m[k+i] = m[l-i];
         m[l-i] = t;
      end
   endtask

   // Called #1 after an edge; returns #1 after the accepting edge
   task automatic issue(input logic [2:0] op, input int k, input int l);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_k     = IW'(k);
      cmd_l     = IW'(l);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic do_cmd(input logic [2:0] op, input int k, input int l, input bit hold,
                         output int nbusy, output logic d, output logic e);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_k     = IW'(k);
      cmd_l     = IW'(l);
      @(posedge clk); #1;
      if (hold) begin
         cmd_op = OpOrf;
         cmd_k  = IW'(0);
         cmd_l  = IW'(1);
      end else begin
         cmd_valid = 1'b0;
      end
      nbusy = 0;
      while (busy && nbusy < 200) begin
         nbusy++;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      if (nbusy >= 200) check("cmd_timeout", 1, 0);
      d = done;
      e = err;
   endtask

   task automatic read_all(input bit tog);
      int            cyc;
      bit            held;
      logic [DW-1:0] prev;
      logic [DW-1:0] exp;
      sb.delete();
      for (int w = 0; w < NW; w++) sb.push_back(pack(w));
      issue(OpRead, 0, 0);
      cyc  = 0;
      held = 1'b0;
      prev = '0;
      while (busy && cyc < 200) begin
         out_ready = tog ? (cyc % 2 == 1) : 1'b1;
         if (held) check("rd_hold", out_data, prev);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("rd_extra", 1, 0);
            end else begin
               exp = sb.pop_front();
               check("rd_data", out_data, exp);
               check("rd_last", out_last, sb.size() == 0);
            end
            held = 1'b0;
         end else begin
            held = out_valid;
            prev = out_data;
         end
         cyc++;
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      if (cyc >= 200) check("rd_timeout", 1, 0);
      check("rd_left", sb.size(), 0);
      check("rd_done", done, 1);
   endtask

   task automatic load_all(input bit tog);
      int            cyc;
      int            b;
      logic [DW-1:0] wd;
      int            v [LN];
      issue(OpLoad, 0, 0);
      cyc = 0;
      b   = 0;
      while (busy && cyc < 200) begin
         in_valid = tog ? (cyc % 2 == 0) : 1'b1;
         wd = '0;
         for (int i = 0; i < LN; i++) begin
            v[i] = $urandom_range(0, 127);
            wd[i*CW +: CW] = CW'(v[i]);
         end
         in_data = wd;
         if (in_valid && in_ready) begin
            for (int i = 0; i < LN; i++) m[b*LN + i] = v[i];
            b++;
         end
         cyc++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (cyc >= 200) check("ld_timeout", 1, 0);
      check("ld_beats", b, NW);
      check("ld_done", done, 1);
   endtask

   initial begin
      int   nb;
      logic d;
      logic e;
      int   op;
      int   k;
      int   l;
      int   eb;

      n_vec     = 0;
      n_err     = 0;
      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = OpNop;
      cmd_k     = '0;
      cmd_l     = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      m_ident();

      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_last", out_last, 0);
      @(posedge clk); @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_cmd_ready", cmd_ready, 1);

      read_all(1'b0);

      do_cmd(OpOrf, 3, 12, 1'b0, nb, d, e);
      m_orf(3, 12);
      check("orf_busy", nb, 2);
      check("orf_done", d, 1);
      check("orf_err", e, 0);
      read_all(1'b0);

      do_cmd(OpOrb, 3, 12, 1'b0, nb, d, e);
      m_orb(3, 12);
      check("orb_busy", nb, 2);
      check("orb_done", d, 1);
      read_all(1'b0);

      // Command held valid throughout the move must be ignored
      do_cmd(OpTwo, 5, 20, 1'b1, nb, d, e);
      m_two(5, 20);
      check("two_busy", nb, 8);
      check("two_done", d, 1);
      check("two_err", e, 0);
      read_all(1'b0);

      do_cmd(OpOrf, 7, 7, 1'b0, nb, d, e);
      check("ill_kl_busy", nb, 0);
      check("ill_kl_done", d, 1);
      check("ill_kl_err", e, 1);
      do_cmd(3'd6, 2, 9, 1'b0, nb, d, e);
      check("ill_op_busy", nb, 0);
      check("ill_op_done", d, 1);
      check("ill_op_err", e, 1);
      do_cmd(OpNop, 0, 0, 1'b0, nb, d, e);
      check("nop_done", d, 0);
      check("nop_err", e, 0);

      // Stray input beats while idle must not touch the route
      in_valid = 1'b1;
      in_data  = '1;
      @(posedge clk); @(posedge clk); #1;
      in_valid = 1'b0;
      check("idle_in_ready", in_ready, 0);
      read_all(1'b0);

      load_all(1'b1);
      read_all(1'b1);

      for (int t = 0; t < 8; t++) begin
         op = $urandom_range(2, 4);
         k  = $urandom_range(0, NC - 2);
         l  = $urandom_range(k + 1, NC - 1);
         if (op == 4) begin
            eb = (l - k + 1) / 2;
            m_two(k, l);
         end else begin
            eb = l / LN - k / LN + 1;
            if (op == 2) m_orf(k, l);
            else m_orb(k, l);
         end
         do_cmd(3'(op), k, l, 1'b0, nb, d, e);
         check("rnd_busy", nb, eb);
         check("rnd_done", d, 1);
         read_all(t[0]);
      end

      issue(OpTwo, 0, 31);
      @(posedge clk); #1;
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      @(posedge clk); #2;
      reset = 1'b1;
      m_ident();
      @(posedge clk); #1;
      check("mid_rst_cmd_ready", cmd_ready, 1);
      check("mid_rst_done2", done, 0);
      @(posedge clk); #1;
      check("mid_rst_done3", done, 0);
      read_all(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/route_opt_engine.md
ROUTE_OPT_ENGINE -- requirements
Module: route_opt_engine

Interface
REQ-001 SHALL have parameter CITY_W, default 7, bits per city id.
REQ-002 SHALL have parameter LANES, default 8, cities per stream word; power of two.
REQ-003 SHALL have parameter N_CITY, default 32, route length; multiple of LANES; IW = clog2(N_CITY), WW = clog2(N_CITY/LANES), minimum 1.
REQ-004 SHALL have port clk, input, 1, sole clock; all state rises on clk.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports cmd_valid input 1, cmd_ready output 1, and cmd_op input 3, where cmd_op is 0 NOP, 1 LOAD, 2 OR_F, 3 OR_B, 4 TWO, 5 READ, and 6-7 are illegal.
REQ-007 SHALL have ports cmd_k input IW and cmd_l input IW, the move positions.
REQ-008 SHALL have ports in_valid input 1, in_ready output 1, and in_data input LANES*CITY_W, with lane i in bits [i*CITY_W +: CITY_W].
REQ-009 SHALL have ports out_valid output 1, out_ready input 1, out_data output LANES*CITY_W, and out_last output 1.
REQ-010 SHALL have ports busy output 1, done output 1 (pulse), and err output 1 (pulse).

Function
REQ-011 SHALL hold the route in N_CITY registers, route[j], j = 0..N_CITY-1; word w covers positions w*LANES..w*LANES+LANES-1.
REQ-012 SHALL use states IDLE, LOAD, ORF, ORB, REV, READ; cmd_ready = (state==IDLE); busy = (state!=IDLE).
REQ-013 SHALL accept a command on a clk edge with cmd_valid&&cmd_ready; NOP is accepted with no effect and no done.
REQ-014 LOAD: SHALL move to LOAD with in_ready=1; each in_valid&&in_ready beat writes word wc (wc from 0); after word N_CITY/LANES-1 SHALL return to IDLE.
REQ-015 READ: SHALL present word rc from 0; out_data/out_valid SHALL stay stable until out_ready; out_last=1 on the final word; after the final handshake SHALL return to IDLE.
REQ-016 OR_F (K<L): SHALL give new[j]=old[j+1] for K<=j<L, new[L]=old[K], and leave other positions unchanged.
REQ-017 OR_F SHALL latch old[K] into a carry register at accept and SHALL update words K/LANES up to L/LANES ascending, one word per cycle; busy for L/LANES-K/LANES+1 cycles.
REQ-018 OR_B (K<L): SHALL give new[j]=old[j-1] for K<j<=L, new[K]=old[L], and leave other positions unchanged.
REQ-019 OR_B SHALL update words L/LANES down to K/LANES descending, one word per cycle, with the carry being old[L]; same cycle count as OR_F.
REQ-020 TWO (K<L): SHALL reverse positions K..L inclusive by swapping one pair (lo,hi) per cycle, starting lo=K, hi=L, then lo+1, hi-1, while lo<hi; busy for floor((L-K+1)/2) cycles.
REQ-021 SHALL pulse done for 1 cycle in the first IDLE cycle after LOAD, OR_F, OR_B, TWO or READ completes.
REQ-022 Illegal command (op 6-7, or K>=L, or L>=N_CITY, for OR_F/OR_B/TWO): SHALL be accepted, SHALL pulse err and done together on the next cycle, SHALL leave the route unchanged, and SHALL stay in IDLE.
REQ-023 cmd_valid while busy SHALL NOT be accepted, and command inputs SHALL be ignored.
REQ-024 in_valid outside LOAD SHALL be ignored; out_valid=0 outside READ.
REQ-025 Word counters SHALL be WW bits, wrap to 0 on completion, and never index beyond N_CITY-1.

Reset
REQ-026 Reset low SHALL asynchronously force state IDLE, route[j]=j (identity, truncated to CITY_W), counters 0, carry 0, busy 0, done 0, err 0, out_valid 0, in_ready 0, out_last 0, and cmd_ready 1 after release.
REQ-027 Reset mid-operation SHALL abandon the operation with no done, and the route SHALL return to identity.

Verification
REQ-028 Reset, READ with out_ready=1 -> 4 words 0..7, 8..15, 16..23, 24..31; out_last on word 3; done 1 cycle later.
REQ-029 OR_F K=3 L=12 on identity -> busy 2 cycles; route[3..11]=4..12, route[12]=3; OR_B K=3 L=12 on that route restores identity.
REQ-030 TWO K=5 L=20 on identity -> busy 8 cycles; route[5..20]=20..5; other positions unchanged.
REQ-031 LOAD with in_valid toggling every other cycle -> exactly 4 beats written, then IDLE; READ with out_ready toggling -> identical words, each held stable until accepted.
REQ-032 OR_F K=7 L=7, and op=6 -> err+done pulse, route unchanged, busy never set; cmd_valid during a TWO -> ignored.
REQ-033 Reset asserted in cycle 3 of TWO K=0 L=31 -> immediate identity, no done, cmd_ready=1 after release.
